// File: rtl/apb_cmd_master.sv
// apb_cmd_master
// APB4 requester: turns a valid/ready command stream into single APB
// transfers (SETUP -> ACCESS). It returns one response per command on a
// valid/ready response channel. Misaligned commands are rejected locally
// and never reach the bus. An optional PREADY wait-state timeout aborts a
// transfer whose slave never answers.
//
// Ports
//   PCLK, PRESET            clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake; cmd_write, cmd_addr,
//                           cmd_wdata, cmd_strb qualify it
//   rsp_valid/rsp_ready     response handshake; rsp_rdata, rsp_err,
//                           rsp_timeout qualify it
//   PSEL, PENABLE, PWRITE,  APB requester outputs
//   PADDR, PWDATA, PSTRB
//   PREADY, PSLVERR, PRDATA APB completer inputs
module apb_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STRB_W         = DATA_W/8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic [STRB_W-1:0] PSTRB,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] PRDATA
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  // Counter is at least one bit wide so a disabled timeout still elaborates.
  localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES+1) : 1;
  localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES-1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

  // Byte-offset bits below the bus width; empty mask for an 8-bit bus.
  localparam int AL_MASK_I = STRB_W-1;
  localparam logic [ADDR_W-1:0] AL_MASK = ADDR_W'(AL_MASK_I);

  logic [1:0]       state;
  logic [CNT_W-1:0] wcnt;
  logic             misal;
  logic             to_hit;

  assign misal  = |(cmd_addr & AL_MASK);
  // wcnt holds the number of PREADY-low ACCESS cycles already completed,
  // so the current cycle is the last allowed one when wcnt == limit-1.
  assign to_hit = (TIMEOUT_CYCLES != 0) && (wcnt == TO_LAST);

  // Gated with PRESET so no command can be taken while reset is held.
  assign cmd_ready = (state == IDLE) && !PRESET;
  assign rsp_valid = (state == RESP);
  assign PSEL      = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      wcnt        <= '0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (misal) begin
              // Rejected locally; APB outputs keep their previous values.
              rsp_rdata   <= '0;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              state       <= RESP;
            end else begin
              PADDR  <= cmd_addr;
              PWRITE <= cmd_write;
              PWDATA <= cmd_write ? cmd_wdata : '0;
              PSTRB  <= cmd_write ? cmd_strb  : '0;
              wcnt   <= '0;
              state  <= SETUP;
            end
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          // PREADY is checked first so a late answer beats the timeout.
          if (PREADY) begin
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
            state       <= RESP;
          end else if (to_hit) begin
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
            state       <= RESP;
          end else begin
            wcnt <= wcnt + CNT_W'(1);
          end
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
